// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier and its restoring-divider partner.
// Provides the FSM state encoding and the default operand/product/counter widths.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int PROD_W        = 2 * DEFAULT_WIDTH;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/busy/done handshake and operand/result bus of the shift-and-add multiplier.
// The requester drives through the master modport; the multiplier uses the slave modport.
interface shift_add_multiplier_if #(
    parameter int WIDTH = mult_pkg::DEFAULT_WIDTH
);

    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   Res;
    logic                 Zero;

    modport master (
        output start, A, B,
        input  busy, done, Res, Zero
    );

    modport slave (
        input  start, A, B,
        output busy, done, Res, Zero
    );

endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier retiring one multiplier bit per clock.
// Define MULT_EARLY_EXIT_EN to stop as soon as the remaining multiplier bits are all zero.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    shift_add_multiplier_if.slave  bus
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    state_e          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   res_q, res_d;
    logic            zero_q, zero_d;
    logic            last_iter;

    // NOTE: every variable gets a default first so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        zero_d    = zero_q;
        last_iter = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    mcand_d = {{WIDTH{1'b0}}, bus.A};
                    mplr_d  = bus.B;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d     = mplr_q[0] ? acc_q + mcand_q : acc_q;
                mcand_d   = mcand_q << 1;
                mplr_d    = mplr_q >> 1;
                cnt_d     = cnt_q + 1'b1;
                last_iter = (cnt_q == CW'(WIDTH - 1));
`ifdef MULT_EARLY_EXIT_EN
                // Once the shifted multiplier is empty, no further partial products can be added.
                last_iter = last_iter || (mplr_d == '0);
`endif
                if (last_iter) begin
                    res_d   = acc_d;
                    zero_d  = (acc_d == '0);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.Res  = res_q;
    assign bus.Zero = zero_q;

endmodule
